mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port 32-bit synchronous RAM (1-cycle read latency) between the instruction fetch bus and the data bus.
- Arbitrates between the two requesters round-robin.
- Extracts byte/halfword read data from the addressed lane.
- Performs read-modify-write for byte and halfword stores.
- Flags misaligned or illegal-size data accesses with an error response and does not touch memory for them.

Parameters:
- ADDR_W, 14, byte-address width decoded by the block (16 KB); word address width is ADDR_W-2.
- RESET_LAST_I, 1, initial round-robin history; 1 means instruction was last granted, so data wins the first tie.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- i_ss  input  1  instruction request (read only)
- i_addr  input  ADDR_W  instruction byte address; bits [1:0] ignored
- i_rdata  output  32  fetched word
- i_bdone  output  1  instruction transfer complete, single-cycle pulse
- d_ss  input  1  data request
- d_ttype  input  1  bus package ttype: READ or WRITE
- d_tsize  input  2  bus package tsize: BYTE, HALFWORD or WORD
- d_addr  input  ADDR_W  data byte address
- d_wdata  input  32  store data, right-justified (byte in [7:0], halfword in [15:0])
- d_rdata  output  32  load data, zero-extended, right-justified
- d_bdone  output  1  data transfer complete, single-cycle pulse
- d_err  output  1  error qualifier, valid only with d_bdone
- mem_en  output  1  RAM chip enable
- mem_we  output  1  RAM write enable
- mem_addr  output  ADDR_W-2  RAM word address
- mem_wdata  output  32  RAM write data
- mem_rdata  input  32  RAM read data, valid the cycle after a read enable

Behaviour:
- Reset (rst_n=0 at clk edge): state IDLE, last grant = RESET_LAST_I.
  - All outputs 0: bdones, d_err, mem_en, mem_we, mem_addr, mem_wdata, i_rdata, d_rdata.
  - Reset asserted mid-transaction aborts it: no bdone, no pending write completes after reset.
- Requester rules:
  - Hold ss, addr, ttype, tsize and wdata stable until the cycle its bdone is high.
  - The next cycle the requester may drop ss or present a new request.
- States: IDLE, RD, WR_ACK, RMW, ERR.
- IDLE:
  - Pick requester: one request wins outright; on a tie, grant the requester not granted last. Update last grant.
  - Instruction: mem_en=1, mem_we=0, mem_addr=i_addr[ADDR_W-1:2] -> RD.
  - Data error check: WORD with addr[1:0]!=0, HALFWORD with addr[0]=1, or an illegal tsize encoding -> ERR, with no mem_en.
  - Data READ: issue read -> RD.
  - Data WRITE WORD: mem_en=1, mem_we=1, mem_wdata=d_wdata -> WR_ACK.
  - Data WRITE BYTE or HALFWORD: issue read of the word -> RMW.
- RD:
  - Pulse the granted bdone.
  - i_rdata = mem_rdata, or d_rdata = lane extract of mem_rdata.
  - Lane extract: byte lane addr[1:0] (00 -> [7:0] … 11 -> [31:24]); halfword addr[1] (0 -> [15:0], 1 -> [31:16]); zero-extended.
  - -> IDLE.
- RMW:
  - mem_en=1, mem_we=1, mem_wdata = mem_rdata with the addressed lane replaced by d_wdata[7:0] or [15:0]; other bytes unchanged.
  - -> WR_ACK.
- WR_ACK: pulse d_bdone with d_err=0 -> IDLE.
- ERR: pulse d_bdone with d_err=1; d_rdata=0 -> IDLE.
- Latency, counted from the cycle a request is accepted in IDLE:
  - Reads, word writes and errors: bdone 1 cycle later.
  - Sub-word writes: bdone 2 cycles later.
  - A losing requester waits for the full transaction plus its own.
- Idle-cycle outputs:
  - mem_en and mem_we are 0 outside the issue cycles above.
  - i_rdata and d_rdata are 0 when their bdone is low.
- Address bits above ADDR_W are ignored.
- Back-to-back: a new request presented the cycle after bdone is accepted in that cycle (IDLE).

Test Plan:
- Word write 0xDEADBEEF @0x0010, then word read @0x0010 -> d_bdone 1 cycle after each accept; d_rdata=0xDEADBEEF, d_err=0.
- Byte store 0xAA @0x0012 over word 0x11223344 -> mem write of 0x11AA3344 in the RMW cycle; d_bdone 2 cycles after accept; byte load @0x0012 -> 0x000000AA; halfword load @0x0012 -> 0x000011AA.
- i_ss and d_ss both high continuously from reset -> grants alternate D, I, D, I; each bdone 1 cycle after accept; neither starves.
- Misaligned WORD @0x0006 and HALFWORD @0x0005 -> d_bdone=1, d_err=1 the next cycle; mem_en never asserted; memory contents unchanged.
- rst_n low during the RMW cycle of a byte store -> no mem_we in the following cycles, no d_bdone, word retains its old value, all outputs 0.
- Instruction fetch @0x0100 while idle, then immediate back-to-back fetch @0x0104 -> i_bdone on cycles 1 and 3 after the first accept, with the correct words.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between the
// instruction fetch bus and the data bus, with sub-word load extract and store RMW.
module mem_port_arbiter #(
  parameter int ADDR_W       = 14,
  parameter bit RESET_LAST_I = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_ss,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_bdone,
  input  logic              d_ss,
  input  logic              d_ttype,
  input  logic [1:0]        d_tsize,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_bdone,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic       TT_READ = 1'b0;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {IDLE, RD, WR_ACK, RMW, ERR} state_t;

  state_t state_p1, state_nxt;
  logic   last_i_p1, last_i_nxt;
  logic   gnt_i_p1, gnt_i_nxt;
  logic   pick_i;

  logic              i_bdone_c, d_bdone_c, d_err_c, mem_en_c, mem_we_c;
  logic [31:0]       i_rdata_c, d_rdata_c, mem_wdata_c;
  logic [ADDR_W-3:0] mem_addr_c;

  // Instruction fetches are word-aligned; the low address bits carry no meaning.
  logic unused_ok;
  assign unused_ok = &{1'b0, i_addr[1:0]};

  function automatic logic bad_access(input logic [1:0] sz, input logic [1:0] a);
    bad_access = (sz == SZ_WORD && a != 2'b00) || (sz == SZ_HALF && a[0]) ||
                 (sz != SZ_BYTE && sz != SZ_HALF && sz != SZ_WORD);
  endfunction

  function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] a,
                                               input logic [1:0] sz);
    lane_extract = w;
    if (sz == SZ_BYTE)      lane_extract = {24'b0, w[{a, 3'b000} +: 8]};
    else if (sz == SZ_HALF) lane_extract = {16'b0, w[{a[1], 4'b0000} +: 16]};
  endfunction

  function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [31:0] d,
                                             input logic [1:0] a, input logic [1:0] sz);
    lane_merge = w;
    if (sz == SZ_BYTE)      lane_merge[{a, 3'b000} +: 8]     = d[7:0];
    else if (sz == SZ_HALF) lane_merge[{a[1], 4'b0000} +: 16] = d[15:0];
  endfunction

  // Stage p1: arbitration state; bus request fields are held stable by the requesters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_p1  <= IDLE;
      last_i_p1 <= RESET_LAST_I;
      gnt_i_p1  <= 1'b0;
    end else begin
      state_p1  <= state_nxt;
      last_i_p1 <= last_i_nxt;
      gnt_i_p1  <= gnt_i_nxt;
    end
  end

  // On a tie the requester that was not granted last wins.
  assign pick_i = i_ss && (!d_ss || !last_i_p1);

  always_comb begin
    state_nxt   = state_p1;
    last_i_nxt  = last_i_p1;
    gnt_i_nxt   = gnt_i_p1;
    i_bdone_c   = 1'b0;
    d_bdone_c   = 1'b0;
    d_err_c     = 1'b0;
    mem_en_c    = 1'b0;
    mem_we_c    = 1'b0;
    mem_addr_c  = '0;
    mem_wdata_c = '0;
    i_rdata_c   = '0;
    d_rdata_c   = '0;
    case (state_p1)
      IDLE: begin
        if (pick_i) begin
          gnt_i_nxt  = 1'b1;
          last_i_nxt = 1'b1;
          mem_en_c   = 1'b1;
          mem_addr_c = i_addr[ADDR_W-1:2];
          state_nxt  = RD;
        end else if (d_ss) begin
          gnt_i_nxt  = 1'b0;
          last_i_nxt = 1'b0;
          if (bad_access(d_tsize, d_addr[1:0])) begin
            state_nxt = ERR;
          end else begin
            mem_en_c   = 1'b1;
            mem_addr_c = d_addr[ADDR_W-1:2];
            if (d_ttype == TT_READ) begin
              state_nxt = RD;
            end else if (d_tsize == SZ_WORD) begin
              mem_we_c    = 1'b1;
              mem_wdata_c = d_wdata;
              state_nxt   = WR_ACK;
            end else begin
              state_nxt = RMW;
            end
          end
        end
      end
      RD: begin
        if (gnt_i_p1) begin
          i_bdone_c = 1'b1;
          i_rdata_c = mem_rdata;
        end else begin
          d_bdone_c = 1'b1;
          d_rdata_c = lane_extract(mem_rdata, d_addr[1:0], d_tsize);
        end
        state_nxt = IDLE;
      end
      RMW: begin
        mem_en_c    = 1'b1;
        mem_we_c    = 1'b1;
        mem_addr_c  = d_addr[ADDR_W-1:2];
        mem_wdata_c = lane_merge(mem_rdata, d_wdata, d_addr[1:0], d_tsize);
        state_nxt   = WR_ACK;
      end
      WR_ACK: begin
        d_bdone_c = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        d_bdone_c = 1'b1;
        d_err_c   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced low while reset is held so an aborted RMW never writes.
  assign i_bdone   = rst_n & i_bdone_c;
  assign d_bdone   = rst_n & d_bdone_c;
  assign d_err     = rst_n & d_err_c;
  assign mem_en    = rst_n & mem_en_c;
  assign mem_we    = rst_n & mem_we_c;
  assign mem_addr  = rst_n ? mem_addr_c  : '0;
  assign mem_wdata = rst_n ? mem_wdata_c : '0;
  assign i_rdata   = rst_n ? i_rdata_c   : '0;
  assign d_rdata   = rst_n ? d_rdata_c   : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: data-bus vector table plus hand-written
// sequences for round-robin, back-to-back fetch and reset during RMW.
module tb_mem_port_arbiter;

  localparam int AW = 14;
  localparam int NV = 21;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_ss, d_ss, d_ttype;
  logic [AW-1:0] i_addr, d_addr;
  logic [1:0]    d_tsize;
  logic [31:0]   d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
  logic          i_bdone, d_bdone, d_err, mem_en, mem_we;
  logic [AW-3:0] mem_addr;

  logic          load_en;
  logic [AW-3:0] load_a;
  logic [31:0]   load_d;
  logic [31:0]   ram [0:4095];
  int            en_cnt, we_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        ttype;
    logic [1:0]  tsize;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_en;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t vecs [0:NV-1];

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .RESET_LAST_I(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_ss(i_ss), .i_addr(i_addr), .i_rdata(i_rdata), .i_bdone(i_bdone),
    .d_ss(d_ss), .d_ttype(d_ttype), .d_tsize(d_tsize), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_bdone(d_bdone), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Single-port synchronous RAM with a bench-side preload port.
  always @(posedge clk) begin
    if (load_en) begin
      ram[load_a] <= load_d;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
    if (mem_en) en_cnt <= en_cnt + 1;
    if (mem_we) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic preload(input logic [AW-3:0] a, input logic [31:0] d);
    load_en = 1'b1;
    load_a  = a;
    load_d  = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " ctl"}, {27'b0, i_bdone, d_bdone, d_err, mem_en, mem_we}, 32'h0);
    chk({nm, " maddr"}, {20'b0, mem_addr}, 32'h0);
    chk({nm, " mwdata"}, mem_wdata, 32'h0);
    chk({nm, " irdata"}, i_rdata, 32'h0);
    chk({nm, " drdata"}, d_rdata, 32'h0);
  endtask

  // Starts and ends on a falling edge.
  task automatic run_vec(input int n);
    int lat;
    int e0;
    logic got;
    logic [31:0] rd;
    logic er;
    e0      = en_cnt;
    d_ss    = 1'b1;
    d_ttype = vecs[n].ttype;
    d_tsize = vecs[n].tsize;
    d_addr  = vecs[n].addr;
    d_wdata = vecs[n].wdata;
    #1;
    chk($sformatf("v%0d accept bdone", n), {31'b0, d_bdone}, 32'h0);
    chk($sformatf("v%0d accept rdata", n), d_rdata, 32'h0);
    lat = 0;
    got = 1'b0;
    rd  = '0;
    er  = 1'b0;
    while (lat < 10 && !got) begin
      @(negedge clk);
      #1;
      lat++;
      if (d_bdone) begin
        got = 1'b1;
        rd  = d_rdata;
        er  = d_err;
      end
    end
    if (!got) chk($sformatf("v%0d timeout", n), 32'h0, 32'h1);
    d_ss = 1'b0;
    chk($sformatf("v%0d latency", n), lat, vecs[n].exp_lat);
    chk($sformatf("v%0d rdata", n), rd, vecs[n].exp_rdata);
    chk($sformatf("v%0d err", n), {31'b0, er}, {31'b0, vecs[n].exp_err});
    @(negedge clk);
    chk($sformatf("v%0d mem_en count", n), en_cnt - e0, vecs[n].exp_en);
    chk($sformatf("v%0d ram word", n), ram[vecs[n].addr[13:2]], vecs[n].exp_mem);
  endtask

  initial begin
    int we0;
    int k;
    vecs[0]  = '{1'b1, 2'd2, 14'h0010, 32'hDEADBEEF, 32'h0,        1'b0, 1, 1, 32'hDEADBEEF};
    vecs[1]  = '{1'b0, 2'd2, 14'h0010, 32'h0,        32'hDEADBEEF, 1'b0, 1, 1, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 2'd2, 14'h0010, 32'h11223344, 32'h0,        1'b0, 1, 1, 32'h11223344};
    vecs[3]  = '{1'b1, 2'd0, 14'h0012, 32'hFFFFFFAA, 32'h0,        1'b0, 2, 2, 32'h11AA3344};
    vecs[4]  = '{1'b0, 2'd0, 14'h0012, 32'h0,        32'h000000AA, 1'b0, 1, 1, 32'h11AA3344};
    vecs[5]  = '{1'b0, 2'd1, 14'h0012, 32'h0,        32'h000011AA, 1'b0, 1, 1, 32'h11AA3344};
    vecs[6]  = '{1'b0, 2'd0, 14'h0013, 32'h0,        32'h00000011, 1'b0, 1, 1, 32'h11AA3344};
    vecs[7]  = '{1'b0, 2'd0, 14'h0011, 32'h0,        32'h00000033, 1'b0, 1, 1, 32'h11AA3344};
    vecs[8]  = '{1'b0, 2'd1, 14'h0010, 32'h0,        32'h00003344, 1'b0, 1, 1, 32'h11AA3344};
    vecs[9]  = '{1'b1, 2'd1, 14'h0010, 32'hABCD5566, 32'h0,        1'b0, 2, 2, 32'h11AA5566};
    vecs[10] = '{1'b1, 2'd0, 14'h0011, 32'h00000077, 32'h0,        1'b0, 2, 2, 32'h11AA7766};
    vecs[11] = '{1'b1, 2'd0, 14'h0013, 32'h12345699, 32'h0,        1'b0, 2, 2, 32'h99AA7766};
    vecs[12] = '{1'b1, 2'd1, 14'h0012, 32'h0000BEEF, 32'h0,        1'b0, 2, 2, 32'hBEEF7766};
    vecs[13] = '{1'b0, 2'd2, 14'h0010, 32'h0,        32'hBEEF7766, 1'b0, 1, 1, 32'hBEEF7766};
    vecs[14] = '{1'b1, 2'd2, 14'h0006, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 32'h0BADF00D};
    vecs[15] = '{1'b1, 2'd1, 14'h0005, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 32'h0BADF00D};
    vecs[16] = '{1'b0, 2'd2, 14'h0002, 32'h0,        32'h0,        1'b1, 1, 0, 32'h01020304};
    vecs[17] = '{1'b1, 2'd3, 14'h0000, 32'hFFFFFFFF, 32'h0,        1'b1, 1, 0, 32'h01020304};
    vecs[18] = '{1'b0, 2'd1, 14'h0006, 32'h0,        32'h00000BAD, 1'b0, 1, 1, 32'h0BADF00D};
    vecs[19] = '{1'b0, 2'd0, 14'h0005, 32'h0,        32'h000000F0, 1'b0, 1, 1, 32'h0BADF00D};
    vecs[20] = '{1'b1, 2'd2, 14'h0020, 32'h55667788, 32'h0,        1'b0, 1, 1, 32'h55667788};

    rst_n = 1'b0; load_en = 1'b0; load_a = '0; load_d = '0;
    i_ss = 1'b0; i_addr = '0; d_ss = 1'b0; d_ttype = 1'b0; d_tsize = 2'd2;
    d_addr = '0; d_wdata = '0; en_cnt = 0; we_cnt = 0;
    @(negedge clk);
    preload(12'h000, 32'h01020304);
    preload(12'h001, 32'h0BADF00D);
    preload(12'h040, 32'hA0A0A0A0);
    preload(12'h041, 32'hB1B1B1B1);
    preload(12'h080, 32'hC0C0C0C0);

    // Both requesters active while reset is held: everything stays low.
    i_ss = 1'b1; i_addr = 14'h0100;
    d_ss = 1'b1; d_ttype = 1'b0; d_tsize = 2'd2; d_addr = 14'h0200;
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous contention from reset: D, I, D, I ...
    for (k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      case (k % 4)
        0: begin
          chk($sformatf("rr%0d ctl", k), {29'b0, i_bdone, d_bdone, mem_en}, 32'h1);
          chk($sformatf("rr%0d addr", k), {20'b0, mem_addr}, 32'h80);
        end
        1: begin
          chk($sformatf("rr%0d ctl", k), {29'b0, i_bdone, d_bdone, mem_en}, 32'h2);
          chk($sformatf("rr%0d drdata", k), d_rdata, 32'hC0C0C0C0);
        end
        2: begin
          chk($sformatf("rr%0d ctl", k), {29'b0, i_bdone, d_bdone, mem_en}, 32'h1);
          chk($sformatf("rr%0d addr", k), {20'b0, mem_addr}, 32'h40);
        end
        default: begin
          chk($sformatf("rr%0d ctl", k), {29'b0, i_bdone, d_bdone, mem_en}, 32'h4);
          chk($sformatf("rr%0d irdata", k), i_rdata, 32'hA0A0A0A0);
        end
      endcase
    end
    i_ss = 1'b0; d_ss = 1'b0;
    @(negedge clk);

    // Back-to-back instruction fetches.
    i_ss = 1'b1; i_addr = 14'h0100;
    #1;
    chk("if0 ctl", {30'b0, i_bdone, mem_en}, 32'h1);
    chk("if0 addr", {20'b0, mem_addr}, 32'h40);
    @(negedge clk); #1;
    chk("if1 bdone", {31'b0, i_bdone}, 32'h1);
    chk("if1 rdata", i_rdata, 32'hA0A0A0A0);
    i_addr = 14'h0104;
    @(negedge clk); #1;
    chk("if2 ctl", {30'b0, i_bdone, mem_en}, 32'h1);
    chk("if2 addr", {20'b0, mem_addr}, 32'h41);
    chk("if2 rdata", i_rdata, 32'h0);
    @(negedge clk); #1;
    chk("if3 bdone", {31'b0, i_bdone}, 32'h1);
    chk("if3 rdata", i_rdata, 32'hB1B1B1B1);
    i_ss = 1'b0;
    @(negedge clk);

    for (int n = 0; n < NV; n++) run_vec(n);

    // Reset lands in the RMW cycle of a byte store to word 0x0020.
    we0 = we_cnt;
    d_ss = 1'b1; d_ttype = 1'b1; d_tsize = 2'd0; d_addr = 14'h0021; d_wdata = 32'h000000AA;
    #1;
    chk("rmwrst issue", {30'b0, mem_en, mem_we}, 32'h2);
    @(negedge clk); #1;
    chk("rmwrst we", {30'b0, mem_en, mem_we}, 32'h3);
    chk("rmwrst wdata", mem_wdata, 32'h5566AA88);
    rst_n = 1'b0; d_ss = 1'b0;
    #1;
    chk_all_zero("rmwrst held");
    @(negedge clk); #1;
    chk_all_zero("rmwrst after");
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk($sformatf("rmwrst idle%0d", c), {30'b0, d_bdone, mem_en}, 32'h0);
    end
    chk("rmwrst we count", we_cnt - we0, 32'h0);
    chk("rmwrst ram", ram[12'h008], 32'h55667788);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
